hex_word_serializer: RTL and testbench

Parametrised successor to the single-nibble hex-to-ASCII converter. Latches a WIDTH-bit word and emits it as a stream of ASCII characters, one per accepted output beat. Characters go most-significant nibble first, with optional "0x" prefix, leading-zero suppression and terminator. Sits between debug taps (register snapshots, PC, bus monitors) and the debug UART transmitter's byte input.

---
 rtl/debug_pkg.sv | 24 ++
 rtl/hex_nibble_ascii.sv | 17 +
 rtl/hex_word_serializer.sv | 120 ++++++++++++
 tb/tb_hex_word_serializer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants for the debug character-output path: serializer state
// encoding and the ASCII codes used when printing hex words.
package debug_pkg;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PFX0  = 3'd1;
  localparam state_t ST_PFX1  = 3'd2;
  localparam state_t ST_DIGIT = 3'd3;
  localparam state_t ST_TERM  = 3'd4;

  localparam int unsigned CHAR_W = 8;

  localparam logic [CHAR_W-1:0] CH_0  = 8'h30;
  localparam logic [CHAR_W-1:0] CH_X  = 8'h78;
  localparam logic [CHAR_W-1:0] CH_LF = 8'h0A;

  // Added to a nibble value 10..15 to land on 'A'..'F' or 'a'..'f'.
  localparam logic [CHAR_W-1:0] CH_UC_OFS = 8'h37;
  localparam logic [CHAR_W-1:0] CH_LC_OFS = 8'h57;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit value to ASCII hex digit converter.
module hex_nibble_ascii
  import debug_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0]        nibble,
  output logic [CHAR_W-1:0] char_c
);

  logic [CHAR_W-1:0] alpha_ofs;

  assign alpha_ofs = UPPERCASE ? CH_UC_OFS : CH_LC_OFS;
  assign char_c    = (nibble < 4'd10) ? (CH_0 + CHAR_W'(nibble))
                                      : (alpha_ofs + CHAR_W'(nibble));

endmodule

// File: rtl/hex_word_serializer.sv
// Latches a word and streams it out as ASCII hex characters (optional "0x"
// prefix, leading-zero suppression and terminator), one per handshake.
module hex_word_serializer
  import debug_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter bit                PREFIX    = 1'b1,
  parameter bit                UPPERCASE = 1'b1,
  parameter bit                SKIP_LZ   = 1'b0,
  parameter bit                TERM_EN   = 1'b1,
  parameter logic [CHAR_W-1:0] TERM_CHAR = CH_LF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef logic [NIBBLES-1:0][3:0] word_t;

  state_t            state_q, state_d;
  word_t             word_q, word_d;
  word_t             in_word;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        nib_sel;
  logic [CHAR_W-1:0] nib_char_c;
  logic [CHAR_W-1:0] char_d;
  logic              valid_d;
  logic              hs;

  // Index of the most-significant non-zero nibble; 0 for an all-zero word.
  function automatic logic [IDX_W-1:0] msnz_idx(input word_t w);
    msnz_idx = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (w[i] != 4'h0) msnz_idx = IDX_W'(i);
    end
  endfunction

  assign in_word = in_data;
  assign hs      = out_valid && out_ready;

  // State register plus the word/index datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      out_char  <= char_d;
      out_valid <= valid_d;
      in_ready  <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic; everything except IDLE advances only on a handshake.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          idx_d   = SKIP_LZ ? msnz_idx(in_word) : IDX_W'(NIBBLES - 1);
          state_d = PREFIX ? ST_PFX0 : ST_DIGIT;
        end
      end
      ST_PFX0: if (hs) state_d = ST_PFX1;
      ST_PFX1: if (hs) state_d = ST_DIGIT;
      ST_DIGIT: begin
        if (hs) begin
          if (idx_q != '0) idx_d   = idx_q - 1'b1;
          else             state_d = TERM_EN ? ST_TERM : ST_IDLE;
        end
      end
      ST_TERM: if (hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The character register is loaded from the upcoming state so it is valid
  // one cycle after acceptance and holds while the sink stalls.
  assign nib_sel = word_d[idx_d];

  hex_nibble_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nibble (
    .nibble (nib_sel),
    .char_c (nib_char_c)
  );

  always_comb begin
    char_d  = 8'h00;
    valid_d = 1'b0;
    case (state_d)
      ST_PFX0:  begin char_d = CH_0;       valid_d = 1'b1; end
      ST_PFX1:  begin char_d = CH_X;       valid_d = 1'b1; end
      ST_DIGIT: begin char_d = nib_char_c; valid_d = 1'b1; end
      ST_TERM:  begin char_d = TERM_CHAR;  valid_d = 1'b1; end
      default:  begin char_d = 8'h00;      valid_d = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_hex_word_serializer.sv
// Scoreboard bench for hex_word_serializer: three configurations driven
// with directed and random words, checked against a digit-level model.
module tb_hex_word_serializer;

  logic             clk;
  logic             rst;
  logic [2:0][63:0] din;
  logic [2:0]       in_valid_s;
  logic [2:0]       in_ready_s;
  logic [2:0][7:0]  out_char_s;
  logic [2:0]       out_valid_s;
  logic [2:0]       out_ready_s;
  logic [2:0]       busy_s;
  bit   [2:0]       rand_rdy;

  logic [7:0] expq [3][$];
  int         checks;
  int         errors;
  int         cyc;
  int         hs_cnt [3];
  int         term_cyc [3];
  bit         stall [3];
  logic [7:0] pchar [3];

  // a: 32-bit defaults; b: 8-bit lowercase, bare digits; c: 64-bit skip-LZ
  hex_word_serializer #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .in_data(din[0][31:0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .out_char(out_char_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .busy(busy_s[0]));

  hex_word_serializer #(.WIDTH(8), .PREFIX(1'b0), .UPPERCASE(1'b0), .SKIP_LZ(1'b0),
                        .TERM_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_data(din[1][7:0]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .out_char(out_char_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .busy(busy_s[1]));

  hex_word_serializer #(.WIDTH(64), .SKIP_LZ(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .out_char(out_char_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .busy(busy_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic flag_fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Reference: the character string a word must produce in configuration k.
  function automatic void push_exp(input int k, input logic [63:0] w);
    int width, nd;
    bit pfx, uc, slz, term;
    logic [3:0] n;
    case (k)
      0:       begin width = 32; pfx = 1; uc = 1; slz = 0; term = 1; end
      1:       begin width = 8;  pfx = 0; uc = 0; slz = 0; term = 0; end
      default: begin width = 64; pfx = 1; uc = 1; slz = 1; term = 1; end
    endcase
    if (width < 64) w = w & ((64'd1 << width) - 64'd1);
    nd = width / 4;
    if (slz) begin
      nd = 1;
      for (int i = 0; i < width / 4; i++)
        if (((w >> (4 * i)) & 64'hF) != 64'd0) nd = i + 1;
    end
    if (pfx) begin
      expq[k].push_back(8'h30);
      expq[k].push_back(8'h78);
    end
    for (int d = nd - 1; d >= 0; d--) begin
      n = 4'((w >> (4 * d)) & 64'hF);
      if (n < 4'd10) expq[k].push_back(8'h30 + 8'(n));
      else           expq[k].push_back((uc ? 8'h41 : 8'h61) + 8'(n) - 8'd10);
    end
    if (term) expq[k].push_back(8'h0A);
  endfunction

  // Monitor: pops and compares on each handshake, checks hold while stalled.
  initial begin
    for (int k = 0; k < 3; k++) begin
      hs_cnt[k] = 0; term_cyc[k] = -10; stall[k] = 0; pchar[k] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          stall[k] = 0;
          expq[k].delete();
        end else begin
          if (stall[k]) begin
            check($sformatf("hold_valid%0d", k), 64'(out_valid_s[k]), 64'd1);
            check($sformatf("hold_char%0d", k), 64'(out_char_s[k]), 64'(pchar[k]));
          end
          if (out_valid_s[k] && out_ready_s[k]) begin
            hs_cnt[k]++;
            if (out_char_s[k] == 8'h0A) term_cyc[k] = cyc;
            if (expq[k].size() == 0)
              flag_fail($sformatf("unexpected_char%0d actual=%0h required=none", k, out_char_s[k]));
            else
              check($sformatf("char%0d", k), 64'(out_char_s[k]), 64'(expq[k].pop_front()));
          end
          stall[k] = out_valid_s[k] && !out_ready_s[k];
          pchar[k] = out_char_s[k];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        if (rand_rdy[k]) out_ready_s[k] = 1'($urandom_range(0, 1));
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int k, input logic [63:0] w);
    int t = 0;
    while (!in_ready_s[k]) begin
      @(posedge clk); #1;
      t++;
      if (t > 3000) begin
        flag_fail($sformatf("send_timeout%0d", k));
        return;
      end
    end
    din[k] = w;
    in_valid_s[k] = 1'b1;
    push_exp(k, w);
    @(posedge clk); #1;
    in_valid_s[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (expq[k].size() != 0 || !in_ready_s[k]) begin
      @(posedge clk); #1;
      t++;
      if (t > 5000) begin
        flag_fail($sformatf("drain_timeout%0d remaining=%0d", k, expq[k].size()));
        expq[k].delete();
        return;
      end
    end
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w >> (4 * $urandom_range(0, 15));
  endfunction

  initial begin
    int base, t, i, nwords;
    logic [63:0] words [8];
    checks = 0; errors = 0;
    rst = 1'b1; din = '0; in_valid_s = '0; out_ready_s = '0; rand_rdy = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_in_ready%0d", k), 64'(in_ready_s[k]), 64'd1);
      check($sformatf("reset_busy%0d", k), 64'(busy_s[k]), 64'd0);
      check($sformatf("reset_out_valid%0d", k), 64'(out_valid_s[k]), 64'd0);
      check($sformatf("reset_out_char%0d", k), 64'(out_char_s[k]), 64'd0);
    end

    // DEADBEEF: one-cycle latency, 11 gapless characters, ready after 0A
    out_ready_s = '1;
    din[0] = 64'hDEADBEEF;
    in_valid_s[0] = 1'b1;
    push_exp(0, 64'hDEADBEEF);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    check("first_char_valid", 64'(out_valid_s[0]), 64'd1);
    check("first_char", 64'(out_char_s[0]), 64'h30);
    check("busy_after_accept", 64'(in_ready_s[0]), 64'd0);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check("stream_no_gap", 64'(out_valid_s[0]), 64'd1);
    end
    @(posedge clk); #1;
    check("ready_after_term", 64'(in_ready_s[0]), 64'd1);
    check("idle_after_term", 64'(out_valid_s[0]), 64'd0);
    check("deadbeef_all_chars", 64'(expq[0].size()), 64'd0);

    send(1, 64'hA5);
    drain(1);
    send(2, 64'h1F0);
    drain(2);
    send(2, 64'h0);
    drain(2);

    // Backpressure with in_valid pulses while busy
    rand_rdy[0] = 1'b1;
    send(0, 64'h12345678);
    repeat (4) begin
      @(posedge clk); #1;
      if (busy_s[0]) begin
        din[0] = 64'($urandom);
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
      end
    end
    drain(0);
    rand_rdy[0] = 1'b0;
    out_ready_s[0] = 1'b1;

    // Reset after the 4th handshake of CAFEF00D
    base = hs_cnt[0];
    send(0, 64'hCAFEF00D);
    t = 0;
    while (hs_cnt[0] < base + 4 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 100) flag_fail("reset_test_handshake_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready_s[0] = 1'b0;
    @(posedge clk); #1;
    check("midreset_out_valid", 64'(out_valid_s[0]), 64'd0);
    check("midreset_in_ready", 64'(in_ready_s[0]), 64'd1);
    check("midreset_busy", 64'(busy_s[0]), 64'd0);
    rst = 1'b0;
    out_ready_s = '1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_chars_after_reset", 64'(out_valid_s[0]), 64'd0);
    end
    send(0, 64'h1);
    drain(0);

    // Back-to-back 64-bit words with in_valid held high
    nwords = 8;
    for (int n = 0; n < nwords; n++) words[n] = rand_word();
    words[0] = 64'h0;
    i = 0; t = 0;
    din[2] = words[0];
    in_valid_s[2] = 1'b1;
    while (i < nwords && t < 3000) begin
      if (in_ready_s[2]) begin
        push_exp(2, din[2]);
        if (i > 0) check("b2b_accept_gap", 64'(cyc - term_cyc[2]), 64'd1);
        i++;
        @(posedge clk); #1;
        if (i < nwords) din[2] = words[i];
      end else begin
        @(posedge clk); #1;
      end
      t++;
    end
    in_valid_s[2] = 1'b0;
    if (i < nwords) flag_fail("b2b_timeout");
    drain(2);

    // Concurrent random traffic with random sink stalls
    rand_rdy = '1;
    fork
      for (int n = 0; n < 15; n++) send(0, rand_word());
      for (int n = 0; n < 15; n++) send(1, 64'($urandom));
      for (int n = 0; n < 15; n++) send(2, rand_word());
    join
    for (int k = 0; k < 3; k++) drain(k);
    rand_rdy = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
